// File: rtl/mem_slot_pkg.sv
// Shared types, slot geometry and phase decoding for the RAM time-slot arbiter.
package mem_slot_pkg;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_CPU  = 2'd1,
        REQ_TUBE = 2'd2,
        REQ_VID  = 2'd3
    } req_id_e;

    localparam int unsigned SLOTS    = 16;
    localparam int unsigned SLOT_LEN = 3;

    localparam logic [15:0] DEF_VID_SLOTS  = 16'h5555;
    localparam logic [15:0] DEF_CPU_SLOTS  = 16'h0202;
    localparam logic [15:0] DEF_TUBE_SLOTS = 16'h2020;

    function automatic logic [3:0] phase_slot(input logic [5:0] ph);
        logic [5:0] q;
        q = ph / 6'(SLOT_LEN);
        return q[3:0];
    endfunction

    function automatic logic [1:0] phase_sub(input logic [5:0] ph);
        logic [5:0] r;
        r = ph % 6'(SLOT_LEN);
        return r[1:0];
    endfunction

    // Round-robin index order is CPU(0) -> TUBE(1) -> VID(2).
    function automatic logic [1:0] id_to_idx(input req_id_e id);
        case (id)
            REQ_TUBE: return 2'd1;
            REQ_VID:  return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

    function automatic req_id_e idx_to_id(input logic [1:0] idx);
        case (idx)
            2'd1:    return REQ_TUBE;
            2'd2:    return REQ_VID;
            default: return REQ_CPU;
        endcase
    endfunction

endpackage

// File: rtl/mem_slot_rr.sv
// 3-way rotating-priority picker: first pending requester at or after the pointer wins.
module mem_slot_rr
    import mem_slot_pkg::*;
(
    input  logic [2:0] pend_i,
    input  req_id_e    ptr_i,
    input  logic       en_i,
    output logic [2:0] grant_o,
    output req_id_e    ptr_o
);

    logic [1:0]  base;
    logic [1:0]  idx;
    logic        found;
    int unsigned j;

    assign base = id_to_idx(ptr_i);

    always_comb begin
        grant_o = '0;
        ptr_o   = ptr_i;
        found   = 1'b0;
        idx     = '0;
        j       = 0;
        for (int unsigned i = 0; i < 3; i++) begin
            j   = (32'(base) + i) % 32'd3;
            idx = j[1:0];
            if (!found && pend_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                if (en_i) ptr_o = idx_to_id((idx == 2'd2) ? 2'd0 : idx + 2'd1);
            end
        end
    end

endmodule

// File: rtl/mem_slot_arbiter.sv
// Shares one async byte-wide RAM between video, CPU and tube in 16 fixed
// three-cycle slots per 48-phase frame; idle slots are donated round-robin.
module mem_slot_arbiter
    import mem_slot_pkg::*;
#(
    parameter int unsigned AW         = 19,
    parameter int unsigned DW         = 8,
    parameter logic [15:0] VID_SLOTS  = DEF_VID_SLOTS,
    parameter logic [15:0] CPU_SLOTS  = DEF_CPU_SLOTS,
    parameter logic [15:0] TUBE_SLOTS = DEF_TUBE_SLOTS
) (
    input  logic          clk_48m,
    input  logic          reset_n,
    input  logic [5:0]    phase,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    input  logic          tube_req,
    input  logic          tube_we,
    input  logic [AW-1:0] tube_addr,
    input  logic [DW-1:0] tube_wdata,
    output logic          tube_ack,
    output logic [DW-1:0] rdata,
    output logic          mem_cs,
    output logic          mem_oe,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic [3:0]    slot;
    logic          arb, done;
    req_id_e       owner, winner, own_q, own_d;
    req_id_e       ptr_q, ptr_d;
    logic          owner_req;
    logic [2:0]    pend, grant;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    logic          cs_q, cs_d, oe_q, oe_d, we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [2:0]    ack_q, ack_d;

    assign slot = phase_slot(phase);
    assign arb  = (phase_sub(phase) == 2'd0);
    assign done = (phase_sub(phase) == 2'd2);
    assign pend = {vid_req, tube_req, cpu_req};

    always_comb begin
        owner     = REQ_NONE;
        owner_req = 1'b0;
        if (VID_SLOTS[slot]) begin
            owner     = REQ_VID;
            owner_req = vid_req;
        end else if (CPU_SLOTS[slot]) begin
            owner     = REQ_CPU;
            owner_req = cpu_req;
        end else if (TUBE_SLOTS[slot]) begin
            owner     = REQ_TUBE;
            owner_req = tube_req;
        end
    end

    // Pointer only advances when the slot is donated or free.
    mem_slot_rr u_rr (
        .pend_i  (pend),
        .ptr_i   (ptr_q),
        .en_i    (arb && !owner_req),
        .grant_o (grant),
        .ptr_o   (ptr_d)
    );

    always_comb begin
        winner = REQ_NONE;
        if (owner_req)     winner = owner;
        else if (grant[0]) winner = REQ_CPU;
        else if (grant[1]) winner = REQ_TUBE;
        else if (grant[2]) winner = REQ_VID;
    end

    always_comb begin
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        case (winner)
            REQ_CPU: begin
                w_we    = cpu_we;
                w_addr  = cpu_addr;
                w_wdata = cpu_wdata;
            end
            REQ_TUBE: begin
                w_we    = tube_we;
                w_addr  = tube_addr;
                w_wdata = tube_wdata;
            end
            REQ_VID: w_addr = vid_addr;
            default: ;
        endcase
    end

    always_comb begin
        cs_d    = cs_q;
        oe_d    = oe_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        own_d   = own_q;
        ack_d   = '0;
        if (arb && winner != REQ_NONE) begin
            cs_d    = 1'b1;
            we_d    = w_we;
            oe_d    = ~w_we;
            addr_d  = w_addr;
            wdata_d = w_wdata;
            own_d   = winner;
        end else if (done && cs_q) begin
            cs_d  = 1'b0;
            oe_d  = 1'b0;
            we_d  = 1'b0;
            own_d = REQ_NONE;
            if (oe_q) rdata_d = mem_rdata;
            case (own_q)
                REQ_CPU:  ack_d[0] = 1'b1;
                REQ_TUBE: ack_d[1] = 1'b1;
                REQ_VID:  ack_d[2] = 1'b1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk_48m) begin
        if (!reset_n) begin
            cs_q    <= 1'b0;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
            own_q   <= REQ_NONE;
            ptr_q   <= REQ_CPU;
        end else begin
            cs_q    <= cs_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
        end
    end

    assign mem_cs    = cs_q;
    assign mem_oe    = oe_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign cpu_ack   = ack_q[0];
    assign tube_ack  = ack_q[1];
    assign vid_ack   = ack_q[2];

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Directed bench for mem_slot_arbiter with hand-computed expectations.
module tb_mem_slot_arbiter;

    logic        clk_48m = 1'b0;
    logic        reset_n;
    logic [5:0]  phase;
    logic        vid_req, cpu_req, cpu_we, tube_req, tube_we;
    logic [18:0] vid_addr, cpu_addr, tube_addr, mem_addr;
    logic [7:0]  cpu_wdata, tube_wdata, rdata, mem_wdata, mem_rdata;
    logic        vid_ack, cpu_ack, tube_ack, mem_cs, mem_oe, mem_we;

    int n_vec = 0;
    int n_err = 0;
    int n_vid, n_cpu, n_tube, s;
    logic [1:0] win [16];

    mem_slot_arbiter #(.AW(19), .DW(8)) dut (
        .clk_48m    (clk_48m),
        .reset_n    (reset_n),
        .phase      (phase),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .tube_req   (tube_req),
        .tube_we    (tube_we),
        .tube_addr  (tube_addr),
        .tube_wdata (tube_wdata),
        .tube_ack   (tube_ack),
        .rdata      (rdata),
        .mem_cs     (mem_cs),
        .mem_oe     (mem_oe),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk_48m = ~clk_48m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (phase %0d)", tag, obs, exp, phase);
        end
    endtask

    // Phase is the value the DUT sees for the cycle that has just started.
    task automatic tick();
        @(posedge clk_48m);
        #1;
        phase = (phase == 6'd47) ? 6'd0 : phase + 6'd1;
    endtask

    task automatic wait_phase(input logic [5:0] p);
        for (int i = 0; i < 48 && phase != p; i++) tick();
    endtask

    initial begin
        phase      = 6'd0;
        reset_n    = 1'b0;
        vid_req    = 1'b1;
        cpu_req    = 1'b1;
        tube_req   = 1'b1;
        cpu_we     = 1'b0;
        tube_we    = 1'b0;
        vid_addr   = 19'h00100;
        cpu_addr   = 19'h00011;
        tube_addr  = 19'h00022;
        cpu_wdata  = 8'h00;
        tube_wdata = 8'h00;
        mem_rdata  = 8'h3C;
        for (int i = 0; i < 16; i++) win[i] = 2'd0;

        // 1: reset with every request asserted
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_ctl", {mem_cs, mem_oe, mem_we, vid_ack, cpu_ack, tube_ack}, 0);
            check("rst_addr", mem_addr, 0);
            check("rst_data", {rdata, mem_wdata}, 0);
        end
        wait_phase(6'd0);
        reset_n = 1'b1;

        // 4: all three requesting for one full frame
        n_vid = 0; n_cpu = 0; n_tube = 0;
        for (int i = 0; i < 48; i++) begin
            tick();
            n_vid  += int'(vid_ack);
            n_cpu  += int'(cpu_ack);
            n_tube += int'(tube_ack);
            if (phase % 3 == 0) begin
                s = ((int'(phase) + 45) % 48) / 3;
                win[s] = vid_ack ? 2'd3 : cpu_ack ? 2'd1 : tube_ack ? 2'd2 : 2'd0;
            end
        end
        check("all_vid_acks", n_vid, 9);
        check("all_cpu_acks", n_cpu, 4);
        check("all_tube_acks", n_tube, 3);
        check("free3_cpu", win[3], 1);
        check("free7_tube", win[7], 2);
        check("free11_vid", win[11], 3);
        check("free15_cpu", win[15], 1);

        // 2: video alone takes every slot
        cpu_req  = 1'b0;
        tube_req = 1'b0;
        for (int i = 0; i < 48; i++) begin
            tick();
            check("vid_ack", vid_ack, (phase % 3 == 0) ? 1 : 0);
            check("vid_we", mem_we, 0);
            if (phase % 3 != 0) begin
                check("vid_oe", {mem_cs, mem_oe}, 2'b11);
                check("vid_addr", mem_addr, 19'h00100);
            end
        end
        check("vid_rdata", rdata, 8'h3C);

        // 3: CPU write in its owned slot 1
        vid_req = 1'b0;
        wait_phase(6'd2);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 19'h01234;
        cpu_wdata = 8'hA5;
        tick();
        check("wr_idle_p3", mem_cs, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("wr_ctl", {mem_cs, mem_we, mem_oe, cpu_ack}, 4'b1100);
            check("wr_addr", mem_addr, 19'h01234);
            check("wr_data", mem_wdata, 8'hA5);
        end
        tick();
        check("wr_ack_p6", {cpu_ack, mem_cs}, 2'b10);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        tick();
        check("wr_ack_p7", cpu_ack, 0);
        check("wr_rdata_kept", rdata, 8'h3C);

        // 5: tube read borrows video slot 0
        wait_phase(6'd47);
        tube_req  = 1'b1;
        tube_we   = 1'b0;
        tube_addr = 19'h7ABCD;
        mem_rdata = 8'h5C;
        tick();
        tick();
        check("tube_ctl", {mem_cs, mem_oe, mem_we}, 3'b110);
        check("tube_addr", mem_addr, 19'h7ABCD);
        tick();
        check("tube_noack_p2", tube_ack, 0);
        tick();
        check("tube_ack_p3", tube_ack, 1);
        check("tube_rdata", rdata, 8'h5C);
        tube_req = 1'b0;

        // 6: reset lands mid-access
        wait_phase(6'd2);
        cpu_req  = 1'b1;
        cpu_addr = 19'h00042;
        tick();
        tick();
        check("mid_cs_p4", mem_cs, 1);
        reset_n = 1'b0;
        tick();
        check("mid_rst_p5", {mem_cs, mem_oe, mem_we}, 0);
        check("mid_rst_rdata", rdata, 0);
        reset_n = 1'b1;
        cpu_req = 1'b0;
        tick();
        check("mid_noack_p6", cpu_ack, 0);
        cpu_req  = 1'b1;
        tube_req = 1'b1;
        tick();
        check("rr_cpu_first", mem_addr, 19'h00042);
        tick();
        tick();
        check("rr_ack_p9", {cpu_ack, tube_ack}, 2'b10);
        cpu_req = 1'b0;
        tick();
        tick();
        tick();
        check("rr_tube_p12", {cpu_ack, tube_ack}, 2'b01);
        tube_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
